// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU/MUL/CMP and a multi-cycle restoring divider.
// The decode stage must hold A/B/ctrl while stall is high.
module exec_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OPCODE_WIDTH   = 4,
  parameter int CTRL_WIDTH     = OPCODE_WIDTH + REG_ADDR_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  input  logic [CTRL_WIDTH-1:0]     ctrl,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_data,
  output logic                      reg_en,
  output logic [1:0]                flags,
  output logic                      dz,
  output logic                      stall
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_CMP  = OPCODE_WIDTH'(7);
  // 8..15: LW, SW, JR, JPC, BRFL, CALL, RET, NOP -- no effect in this stage

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]     quo_q, quo_d;
  logic [DATA_WIDTH-1:0]     dvs_q, dvs_d;
  logic                      neg_q, neg_d;
  logic                      divz_q, divz_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]     reg_data_q, reg_data_d;
  logic                      reg_en_q, reg_en_d;
  logic [1:0]                flags_q, flags_d;
  logic                      dz_q, dz_d;

  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]     abs_a, abs_b;
  logic [DATA_WIDTH:0]       shifted;
  logic [DATA_WIDTH-1:0]     quo_signed;

  assign opcode = ctrl[OPCODE_WIDTH-1:0];
  assign rd     = ctrl[CTRL_WIDTH-1:OPCODE_WIDTH];

  // Magnitudes as unsigned W-bit values; the most negative input maps to 2^(W-1).
  assign abs_a = A[DATA_WIDTH-1] ? (~A) + DATA_WIDTH'(1) : A;
  assign abs_b = B[DATA_WIDTH-1] ? (~B) + DATA_WIDTH'(1) : B;

  // Partial remainder stays below the divisor, so W bits plus the shifted-in bit suffice.
  assign shifted    = {rem_q, quo_q[DATA_WIDTH-1]};
  assign quo_signed = neg_q ? (~quo_q) + DATA_WIDTH'(1) : quo_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_d      = neg_q;
    divz_d     = divz_q;
    rd_d       = rd_q;
    reg_en_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    flags_d    = flags_q;
    dz_d       = dz_q;

    case (state_q)
      IDLE: begin
        case (opcode)
          OP_ADD: begin
            reg_en_d   = 1'b1;
            reg_addr_d = rd;
            reg_data_d = A + B;
          end
          OP_SUB: begin
            reg_en_d   = 1'b1;
            reg_addr_d = rd;
            reg_data_d = A - B;
          end
          OP_AND: begin
            reg_en_d   = 1'b1;
            reg_addr_d = rd;
            reg_data_d = A & B;
          end
          OP_OR: begin
            reg_en_d   = 1'b1;
            reg_addr_d = rd;
            reg_data_d = A | B;
          end
          OP_NOT: begin
            reg_en_d   = 1'b1;
            reg_addr_d = rd;
            reg_data_d = ~A;
          end
          OP_MUL: begin
            // Low W bits of a product do not depend on operand signedness.
            reg_en_d   = 1'b1;
            reg_addr_d = rd;
            reg_data_d = A * B;
          end
          OP_CMP: begin
            flags_d = {($signed(A) < $signed(B)), (A == B)};
          end
          OP_DIV: begin
            state_d = DIV_RUN;
            cnt_d   = CNT_W'(DATA_WIDTH);
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            neg_d   = A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
            divz_d  = (B == '0);
            rd_d    = rd;
          end
          default: ;
        endcase
      end

      DIV_RUN: begin
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = shifted[DATA_WIDTH-1:0] - dvs_q;
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_DONE;
        end
      end

      DIV_DONE: begin
        reg_en_d   = 1'b1;
        reg_addr_d = rd_q;
        reg_data_d = divz_q ? '1 : quo_signed;
        if (divz_q) begin
          dz_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
      divz_q     <= 1'b0;
      rd_q       <= '0;
      reg_en_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      flags_q    <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_q      <= neg_d;
      divz_q     <= divz_d;
      rd_q       <= rd_d;
      reg_en_q   <= reg_en_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      flags_q    <= flags_d;
      dz_q       <= dz_d;
    end
  end

  assign stall    = (state_q != IDLE);
  assign reg_en   = reg_en_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign flags    = flags_q;
  assign dz       = dz_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed-vector bench for exec_stage at DATA_WIDTH=16.
module tb_exec_stage;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_NOP = 4'd15;

  logic        clk_in = 1'b0;
  logic        RST    = 1'b1;
  logic [15:0] A      = '0;
  logic [15:0] B      = '0;
  logic [8:0]  ctrl   = {5'd0, OP_NOP};
  logic [4:0]  reg_addr;
  logic [15:0] reg_data;
  logic        reg_en;
  logic [1:0]  flags;
  logic        dz;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  exec_stage #(
    .DATA_WIDTH    (16),
    .REG_ADDR_WIDTH(5),
    .OPCODE_WIDTH  (4)
  ) dut (
    .clk_in  (clk_in),
    .RST     (RST),
    .A       (A),
    .B       (B),
    .ctrl    (ctrl),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .reg_en  (reg_en),
    .flags   (flags),
    .dz      (dz),
    .stall   (stall)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd,
                       input logic [15:0] a, input logic [15:0] b);
    ctrl = {rd, op};
    A    = a;
    B    = b;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                       input logic [15:0] a, input logic [15:0] b);
    drive(op, rd, a, b);
    step();
  endtask

  // Issues a DIV, holds an ADD (1+2 -> r5) on the inputs during the stall,
  // and checks stall length, the quotient write and the single held write.
  task automatic run_div(input string tag, input logic [4:0] rd,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q);
    int stall_cycles = 0;
    int bad_en = 0;
    int held_writes = 0;
    issue(OP_DIV, rd, a, b);
    drive(OP_ADD, 5'd5, 16'd1, 16'd2);
    while (stall && stall_cycles < 40) begin
      if (reg_en) bad_en++;
      stall_cycles++;
      step();
    end
    check_val({tag, " stall cycles"}, stall_cycles, 17);
    check_val({tag, " reg_en during stall"}, bad_en, 0);
    check_val({tag, " div reg_en"}, reg_en, 1);
    check_val({tag, " div reg_addr"}, reg_addr, rd);
    check_val({tag, " div reg_data"}, reg_data, exp_q);
    for (int i = 0; i < 3; i++) begin
      step();
      if (reg_en && reg_addr == 5'd5 && reg_data == 16'd3) held_writes++;
      if (i == 0) drive(OP_NOP, 5'd0, 16'd0, 16'd0);
    end
    check_val({tag, " held ADD writes"}, held_writes, 1);
  endtask

  initial begin
    #2 RST = 1'b0;
    #1;
    check_val("reset reg_en",   reg_en,   0);
    check_val("reset reg_addr", reg_addr, 0);
    check_val("reset reg_data", reg_data, 0);
    check_val("reset flags",    flags,    0);
    check_val("reset dz",       dz,       0);
    check_val("reset stall",    stall,    0);
    @(posedge clk_in);
    #1 RST = 1'b1;

    issue(OP_ADD, 5'd3, 16'd5, 16'd7);
    check_val("ADD reg_en",   reg_en,   1);
    check_val("ADD reg_addr", reg_addr, 3);
    check_val("ADD reg_data", reg_data, 12);
    check_val("ADD stall",    stall,    0);
    issue(OP_NOP, 5'd0, 16'd0, 16'd0);
    check_val("ADD pulse end", reg_en, 0);

    issue(OP_SUB, 5'd31, 16'd5, 16'd9);
    check_val("SUB reg_addr", reg_addr, 31);
    check_val("SUB reg_data", reg_data, 16'hFFFC);
    issue(OP_MUL, 5'd1, 16'd300, 16'd300);
    check_val("MUL reg_data", reg_data, 24464);
    issue(OP_ADD, 5'd6, 16'h7FFF, 16'h0001);
    check_val("ADD wrap", reg_data, 16'h8000);
    issue(OP_AND, 5'd7, 16'hF0F0, 16'h3C3C);
    check_val("AND reg_data", reg_data, 16'h3030);
    issue(OP_OR, 5'd8, 16'hF000, 16'h000F);
    check_val("OR reg_data", reg_data, 16'hF00F);
    issue(OP_NOT, 5'd9, 16'h1234, 16'hFFFF);
    check_val("NOT reg_data", reg_data, 16'hEDCB);
    issue(OP_MUL, 5'd10, 16'hFFFD, 16'd7);
    check_val("MUL signed", reg_data, 16'hFFEB);

    issue(OP_CMP, 5'd11, 16'd3, 16'd9);
    check_val("CMP lt flags",  flags,  2'b10);
    check_val("CMP lt reg_en", reg_en, 0);
    issue(OP_CMP, 5'd11, 16'd9, 16'd9);
    check_val("CMP eq flags", flags, 2'b01);
    issue(OP_CMP, 5'd11, 16'hFFFF, 16'd1);
    check_val("CMP neg flags", flags, 2'b10);
    issue(OP_CMP, 5'd11, 16'd9, 16'd9);
    issue(OP_LW, 5'd12, 16'd1, 16'd2);
    check_val("LW flags kept", flags,  2'b01);
    check_val("LW reg_en",     reg_en, 0);

    run_div("DIV -145/4", 5'd2, 16'hFF6F, 16'd4, 16'hFFDC);
    check_val("dz clear", dz, 0);
    run_div("DIV 7/0", 5'd13, 16'd7, 16'd0, 16'hFFFF);
    check_val("dz set", dz, 1);
    run_div("DIV min/-1", 5'd14, 16'h8000, 16'hFFFF, 16'h8000);
    check_val("dz sticky", dz, 1);

    issue(OP_DIV, 5'd15, 16'd100, 16'd3);
    drive(OP_NOP, 5'd0, 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) step();
    check_val("pre-abort stall", stall, 1);
    RST = 1'b0;
    #1;
    check_val("abort stall",    stall,    0);
    check_val("abort reg_en",   reg_en,   0);
    check_val("abort reg_addr", reg_addr, 0);
    check_val("abort reg_data", reg_data, 0);
    check_val("abort flags",    flags,    0);
    check_val("abort dz",       dz,       0);
    step();
    RST = 1'b1;
    begin
      int stray = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (reg_en || stall) stray++;
      end
      check_val("abort no write", stray, 0);
    end
    issue(OP_ADD, 5'd4, 16'd1, 16'd1);
    check_val("post-abort reg_en",   reg_en,   1);
    check_val("post-abort reg_addr", reg_addr, 4);
    check_val("post-abort reg_data", reg_data, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
